// File: rtl/ntt_bf_scheduler.sv
// Butterfly sequencer for one iterative N-point NTT: walks the stage and butterfly counters, issues address/twiddle descriptors.
// Optional macro NTT_SCHED_INTT_EN: inverse=1 at start runs the stages in descending (Gentleman-Sande) order.
module ntt_bf_scheduler #(
   parameter int LOGN      = 3,
   parameter int STAGE_GAP = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            inverse,
   output logic            busy,
   output logic            done,
   output logic            bf_valid,
   input  logic            bf_ready,
   output logic [LOGN-1:0] addr_a,
   output logic [LOGN-1:0] addr_b,
   output logic [LOGN-2:0] tw_idx,
   output logic [LOGN-1:0] stage
);

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);
   localparam logic [LOGN-1:0] STAGE_ONE  = LOGN'(1);
   localparam logic [LOGN:0]   EXT_ONE    = (LOGN + 1)'(1);
   localparam logic [3:0]      GAP_LAST   = 4'(STAGE_GAP - 1);

   state_t          state, state_next;
   logic [LOGN-1:0] stage_cnt, stage_cnt_next;
   logic [LOGN-2:0] bf_cnt, bf_cnt_next;
   logic [3:0]      gap_cnt, gap_cnt_next;
   logic            inv_mode;
   logic [LOGN-1:0] start_stage;

`ifdef NTT_SCHED_INTT_EN
   logic inv_latch, inv_latch_next;
   assign inv_mode    = inv_latch;
   assign start_stage = inverse ? STAGE_LAST : '0;
`else
   logic unused_inverse;
   assign unused_inverse = inverse;
   assign inv_mode       = 1'b0;
   assign start_stage    = '0;
`endif

   logic [LOGN-1:0] last_stage, stage_step;
   logic            xfer, bf_last;

   assign last_stage = inv_mode ? '0 : STAGE_LAST;
   assign stage_step = inv_mode ? (stage_cnt - STAGE_ONE) : (stage_cnt + STAGE_ONE);
   assign xfer       = (state == RUN) && bf_ready;
   assign bf_last    = (bf_cnt == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         stage_cnt <= '0;
         bf_cnt    <= '0;
         gap_cnt   <= '0;
`ifdef NTT_SCHED_INTT_EN
         inv_latch <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         stage_cnt <= stage_cnt_next;
         bf_cnt    <= bf_cnt_next;
         gap_cnt   <= gap_cnt_next;
`ifdef NTT_SCHED_INTT_EN
         inv_latch <= inv_latch_next;
`endif
      end
   end

   always_comb begin
      state_next     = state;
      stage_cnt_next = stage_cnt;
      bf_cnt_next    = bf_cnt;
      gap_cnt_next   = gap_cnt;
`ifdef NTT_SCHED_INTT_EN
      inv_latch_next = inv_latch;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_next     = RUN;
               stage_cnt_next = start_stage;
               bf_cnt_next    = '0;
`ifdef NTT_SCHED_INTT_EN
               inv_latch_next = inverse;
`endif
            end
         end
         RUN: begin
            if (xfer) begin
               if (bf_last) begin
                  bf_cnt_next = '0;
                  if (stage_cnt == last_stage) begin
                     state_next = DONE;
                  end else begin
                     stage_cnt_next = stage_step;
                     gap_cnt_next   = '0;
                     // A zero gap chains stages back-to-back without visiting GAP.
                     state_next     = (STAGE_GAP == 0) ? RUN : GAP;
                  end
               end else begin
                  bf_cnt_next = bf_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_next   = RUN;
               gap_cnt_next = '0;
            end else begin
               gap_cnt_next = gap_cnt + 1'b1;
            end
         end
         DONE: begin
            state_next     = IDLE;
            stage_cnt_next = '0;
            bf_cnt_next    = '0;
            gap_cnt_next   = '0;
`ifdef NTT_SCHED_INTT_EN
            inv_latch_next = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // Address arithmetic is done one bit wider so the (s+1) shift never loses the top bit.
   logic [LOGN:0] bf_ext, h_ext, k_ext, a_ext, tw_ext;

   always_comb begin
      bf_ext = {2'b00, bf_cnt};
      h_ext  = EXT_ONE << stage_cnt;
      k_ext  = bf_ext & (h_ext - EXT_ONE);
      a_ext  = ((bf_ext >> stage_cnt) << (int'(stage_cnt) + 1)) | k_ext;
      tw_ext = k_ext << (LOGN - 1 - int'(stage_cnt));
   end

   assign bf_valid = (state == RUN);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign stage    = stage_cnt;
   assign addr_a   = bf_valid ? a_ext[LOGN-1:0] : '0;
   assign addr_b   = bf_valid ? (a_ext[LOGN-1:0] | h_ext[LOGN-1:0]) : '0;
   assign tw_idx   = bf_valid ? tw_ext[LOGN-2:0] : '0;

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler (LOGN=3): one instance with STAGE_GAP=2, one with STAGE_GAP=0.
module tb_ntt_bf_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_g = 1'b0;
   logic       start_z = 1'b0;
   logic       inverse = 1'b0;
   logic       bf_ready = 1'b0;
   logic       sel = 1'b0;

   logic       busy_g, done_g, bf_valid_g, busy_z, done_z, bf_valid_z;
   logic [2:0] addr_a_g, addr_b_g, stage_g, addr_a_z, addr_b_z, stage_z;
   logic [1:0] tw_idx_g, tw_idx_z;

   logic       m_busy, m_done, m_valid;
   logic [2:0] m_a, m_b, m_stage;
   logic [1:0] m_tw;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef NTT_SCHED_INTT_EN
   localparam bit INV_EXP = 1'b1;
`else
   localparam bit INV_EXP = 1'b0;
`endif

   int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   always #5 clk = ~clk;

   ntt_bf_scheduler #(.LOGN(3), .STAGE_GAP(2)) dut_g (
      .clk(clk), .rst(rst), .start(start_g), .inverse(inverse),
      .busy(busy_g), .done(done_g), .bf_valid(bf_valid_g), .bf_ready(bf_ready),
      .addr_a(addr_a_g), .addr_b(addr_b_g), .tw_idx(tw_idx_g), .stage(stage_g)
   );

   ntt_bf_scheduler #(.LOGN(3), .STAGE_GAP(0)) dut_z (
      .clk(clk), .rst(rst), .start(start_z), .inverse(inverse),
      .busy(busy_z), .done(done_z), .bf_valid(bf_valid_z), .bf_ready(bf_ready),
      .addr_a(addr_a_z), .addr_b(addr_b_z), .tw_idx(tw_idx_z), .stage(stage_z)
   );

   assign m_busy  = sel ? busy_z     : busy_g;
   assign m_done  = sel ? done_z     : done_g;
   assign m_valid = sel ? bf_valid_z : bf_valid_g;
   assign m_a     = sel ? addr_a_z   : addr_a_g;
   assign m_b     = sel ? addr_b_z   : addr_b_g;
   assign m_tw    = sel ? tw_idx_z   : tw_idx_g;
   assign m_stage = sel ? stage_z    : stage_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start_z = v;
      else     start_g = v;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"},   32'(m_busy),  0);
      chk({tag, ".done"},   32'(m_done),  0);
      chk({tag, ".valid"},  32'(m_valid), 0);
      chk({tag, ".addr_a"}, 32'(m_a),     0);
      chk({tag, ".addr_b"}, 32'(m_b),     0);
      chk({tag, ".tw"},     32'(m_tw),    0);
      chk({tag, ".stage"},  32'(m_stage), 0);
   endtask

   // Runs one transform on the selected instance and scores every beat against the table.
   task automatic run(input string tag, input bit rnd, input bit inv_exp, input bit spam, input int exp_done);
      int         beats, done_cnt, done_cyc, idx;
      bit         stalled;
      logic [2:0] ha, hb, hs;
      logic [1:0] ht;
      beats = 0; done_cnt = 0; done_cyc = -1; stalled = 1'b0;
      ha = '0; hb = '0; hs = '0; ht = '0;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      for (int cyc = 1; cyc <= 150; cyc++) begin
         if (cyc == 1) begin
            chk({tag, ".first_valid"}, 32'(m_valid), 1);
            chk({tag, ".first_busy"},  32'(m_busy),  1);
         end
         if (stalled) begin
            chk({tag, ".hold_valid"}, 32'(m_valid), 1);
            chk({tag, ".hold_a"},     32'(m_a),     32'(ha));
            chk({tag, ".hold_b"},     32'(m_b),     32'(hb));
            chk({tag, ".hold_tw"},    32'(m_tw),    32'(ht));
            chk({tag, ".hold_stage"}, 32'(m_stage), 32'(hs));
         end
         if (m_done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
         end
         bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (spam) set_start(m_busy);
         stalled = 1'b0;
         if (m_valid) begin
            if (bf_ready) begin
               if (beats < 12) begin
                  idx = inv_exp ? ((2 - beats / 4) * 4 + beats % 4) : beats;
                  chk({tag, ".addr_a"}, 32'(m_a),     exp_a[idx]);
                  chk({tag, ".addr_b"}, 32'(m_b),     exp_b[idx]);
                  chk({tag, ".tw"},     32'(m_tw),    exp_t[idx]);
                  chk({tag, ".stage"},  32'(m_stage), idx / 4);
                  $display("%s beat %0d: stage=%0d a=%0d b=%0d tw=%0d", tag, beats, m_stage, m_a, m_b, m_tw);
               end
               beats++;
            end else begin
               stalled = 1'b1;
               ha = m_a; hb = m_b; ht = m_tw; hs = m_stage;
            end
         end
         if (done_cnt > 0 && cyc >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      set_start(1'b0);
      bf_ready = 1'b0;
      chk({tag, ".beats"},     beats,    12);
      chk({tag, ".done_cnt"},  done_cnt, 1);
      if (exp_done > 0) chk({tag, ".done_cycle"}, done_cyc, exp_done);
      chk({tag, ".idle_after"}, 32'(m_busy), 0);
      $display("%s complete: beats=%0d done_cycle=%0d", tag, beats, done_cyc);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset_held");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle("reset_released");

      run("t1_forward", 1'b0, 1'b0, 1'b0, 17);
      run("t2_random_ready", 1'b1, 1'b0, 1'b0, 0);
      run("t3_start_spam", 1'b0, 1'b0, 1'b1, 17);

      // Abort after five transferred beats (cycles 1-4 and 7), then check the async clear.
      bf_ready = 1'b1;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      repeat (7) @(posedge clk);
      #1;
      chk("t4_pre_abort_busy", 32'(m_busy), 1);
      rst = 1'b1;
      #1;
      chk_idle("t4_abort");
      bf_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t4_no_done", 32'(m_done), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      run("t4_restart", 1'b0, 1'b0, 1'b0, 17);

      sel = 1'b1;
      @(posedge clk); #1;
      run("t5_gap0", 1'b0, 1'b0, 1'b0, 13);

      sel = 1'b0;
      inverse = 1'b1;
      @(posedge clk); #1;
      run("t6_inverse", 1'b0, INV_EXP, 1'b0, 17);
      inverse = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
